// File: rtl/uart_pkg.sv
// uart_pkg: constants and parity helper shared by the UART transmit
// and receive blocks.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int K_W        = 19;
  localparam int START_POS  = 0;
  localparam int STOP_POS   = 10;
  localparam int CNT_W      = 4;

  // Parity over the 7 or 8 data bits in use; odd sense inverts.
  function automatic logic parity(
    input logic [7:0] data,
    input logic       eight,
    input logic       ohel
  );
    logic p;
    p = ^data[6:0];
    if (eight) p = p ^ data[7];
    return p ^ ohel;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free counter 0..k while enabled, one-clock btu at k.
// Held at zero while disabled so every bit starts on a fresh count.
module uart_bit_timer #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] k,
  output logic         btu
);

  logic [W-1:0] cnt;

  assign btu = en && (cnt == k);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || btu) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_transmit.sv
// uart_transmit: frames a byte (start, 7/8 data, parity, stop) onto tx.
// Defining UART_TX_BREAK_EN adds brk, which holds the line low.
module uart_transmit
  import uart_pkg::*;
#(
  parameter int FRAME_BITS = uart_pkg::FRAME_BITS,
  parameter int K_W        = uart_pkg::K_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [7:0]     out_port,
  input  logic           eight,
  input  logic           parity_en,
  input  logic           ohel,
  input  logic [K_W-1:0] k,
`ifdef UART_TX_BREAK_EN
  input  logic           brk,
`endif
  output logic           tx,
  output logic           TXRDY
);

  logic brk_w;
`ifdef UART_TX_BREAK_EN
  assign brk_w = brk;
`else
  assign brk_w = 1'b0;
`endif

  logic [7:0]            hold;
  logic                  load_d1;
  logic                  doit;
  logic                  btu;
  logic                  acc;
  logic                  done;
  logic                  par;
  logic                  brk_q;
  logic                  brk_idle;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] sr;
  logic [FRAME_BITS-1:0] frame;

  assign acc      = load & TXRDY & ~brk_w;
  assign done     = btu && (bit_cnt == CNT_W'(FRAME_BITS - 1));
  assign brk_idle = brk_w & ~doit & ~load_d1;
  assign par      = parity(hold, eight, ohel);

  always_comb begin
    frame            = '1;
    frame[START_POS] = 1'b0;
    frame[7:1]       = hold[6:0];
    frame[8]         = eight ? hold[7] : (parity_en ? par : 1'b1);
    frame[9]         = (eight & parity_en) ? par : 1'b1;
    frame[STOP_POS]  = 1'b1;
  end

  uart_bit_timer #(
    .W(K_W)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .en (doit),
    .k  (k),
    .btu(btu)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold    <= '0;
      load_d1 <= 1'b0;
      doit    <= 1'b0;
      bit_cnt <= '0;
      sr      <= '1;
      tx      <= 1'b1;
      TXRDY   <= 1'b1;
      brk_q   <= 1'b0;
    end else begin
      load_d1 <= acc;
      brk_q   <= brk_idle;
      if (acc) begin
        hold  <= out_port;
        TXRDY <= 1'b0;
      end
      if (load_d1) begin
        sr      <= frame;
        doit    <= 1'b1;
        bit_cnt <= '0;
      end else if (btu) begin
        sr      <= {1'b1, sr[FRAME_BITS-1:1]};
        bit_cnt <= done ? '0 : bit_cnt + 1'b1;
        if (done) begin
          doit  <= 1'b0;
          TXRDY <= ~brk_w;
        end
      end
      // A break only starts between frames and owns the line until released.
      if (brk_idle) begin
        tx    <= 1'b0;
        TXRDY <= 1'b0;
      end else begin
        tx <= doit ? sr[0] : 1'b1;
        if (brk_q) TXRDY <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: randomized frames against a bit-list model,
// checked per clock on tx by a scoreboard monitor.
module tb_uart_transmit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  out_port = '0;
  logic        eight = 1'b1;
  logic        parity_en = 1'b0;
  logic        ohel = 1'b0;
  logic [18:0] k = '0;
  logic        tx;
  logic        TXRDY;
`ifdef UART_TX_BREAK_EN
  logic        brk = 1'b0;
`endif

  typedef struct {
    logic [10:0] bits;
    int          kk;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   cur_k = 0;
  int   idle_cnt = 0;
  bit   mon_busy = 0;
  bit   chk_gap = 0;
  bit   quiet = 0;

  uart_transmit dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .out_port (out_port),
    .eight    (eight),
    .parity_en(parity_en),
    .ohel     (ohel),
    .k        (k),
`ifdef UART_TX_BREAK_EN
    .brk      (brk),
`endif
    .tx       (tx),
    .TXRDY    (TXRDY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] model_frame(
    input logic [7:0] d,
    input logic       e,
    input logic       pe,
    input logic       o
  );
    bit          q[$];
    bit          p;
    int          n;
    logic [10:0] f;
    n = e ? 8 : 7;
    p = o;
    q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe) q.push_back(p);
    while (q.size() < 11) q.push_back(1'b1);
    for (int i = 0; i < 11; i++) f[i] = q[i];
    return f;
  endfunction

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] want
  );
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  task automatic start_frame(
    input logic [7:0] d,
    input int         kk,
    input logic       e,
    input logic       pe,
    input logic       o,
    input bit         scramble
  );
    exp_t x;
    k         = 19'(kk);
    eight     = e;
    parity_en = pe;
    ohel      = o;
    out_port  = d;
    load      = 1'b1;
    @(posedge clk); #1;
    load    = 1'b0;
    acc_cyc = cyc;
    cur_k   = kk;
    x.bits  = model_frame(d, e, pe, o);
    x.kk    = kk;
    sbq.push_back(x);
    check("txrdy_low_after_load", 32'(TXRDY), 0);
    if (scramble) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      eight     = 1'($urandom);
      parity_en = 1'($urandom);
      ohel      = 1'($urandom);
      out_port  = 8'($urandom);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (TXRDY !== 1'b1 && n < 11 * (cur_k + 1) + 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("txrdy_rise_cycle", 32'(cyc - acc_cyc), 32'(1 + 11 * (cur_k + 1)));
  endtask

  initial begin : monitor
    exp_t        cur;
    int          mism;
    int          first;
    int          kp;
    int          w;
    bit          aborted;
    logic        want;
    logic [10:0] got;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || quiet) continue;
      if (tx !== 1'b0) begin
        idle_cnt++;
        continue;
      end
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_start: tx=%b with no frame queued", tx);
        w = 0;
        while (tx !== 1'b1 && w < 3000) begin
          @(negedge clk);
          w++;
        end
        continue;
      end
      mon_busy = 1;
      if (chk_gap) check("b2b_idle_clocks_le2", 32'(idle_cnt <= 2), 1);
      cur     = sbq.pop_front();
      kp      = cur.kk + 1;
      mism    = 0;
      first   = 0;
      aborted = 0;
      got     = '1;
      for (int c = 0; c < 11 * kp; c++) begin
        if (c > 0) @(negedge clk);
        if (rst !== 1'b0) begin
          aborted = 1;
          break;
        end
        want = cur.bits[c / kp];
        if (c % kp == kp / 2) got[c / kp] = tx;
        if (tx !== want) begin
          if (mism == 0) first = c;
          mism++;
        end
      end
      if (!aborted) begin
        tests++;
        if (mism != 0) begin
          fails++;
          $display("FAIL frame: got bits %b, expected %b (%0d bad clocks, first %0d)",
                   got, cur.bits, mism, first);
        end
      end
      idle_cnt = 0;
      mon_busy = 0;
    end
  end

  initial begin : stim
    int n;
    #100;
    check("reset_tx", 32'(tx), 1);
    check("reset_txrdy", 32'(TXRDY), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    start_frame(8'hAE, 108, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("tx_high_1clk_after_load", 32'(tx), 1);
    @(posedge clk); #1;
    check("tx_start_2clk_after_load", 32'(tx), 0);
    wait_ready();

    start_frame(8'hAE, 108, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_ready();
    start_frame(8'hAE, 108, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_ready();

    start_frame(8'hAE, 108, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    out_port = 8'h55;
    load     = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check("ignored_load_txrdy", 32'(TXRDY), 0);
    wait_ready();

    chk_gap = 1;
    start_frame(8'h5A, 108, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_ready();
    chk_gap = 0;

    start_frame(8'hAE, 108, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2 + 4 * 109 + 54) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    check("midframe_rst_tx", 32'(tx), 1);
    check("midframe_rst_txrdy", 32'(TXRDY), 1);
    #20;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    start_frame(8'h3C, 108, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_ready();

    for (int i = 0; i < 24; i++) begin
      start_frame(8'($urandom), $urandom_range(0, 6), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'b1);
      wait_ready();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    n = 0;
    while ((sbq.size() != 0 || mon_busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drained", 32'(sbq.size()) + 32'(mon_busy), 0);

`ifdef UART_TX_BREAK_EN
    quiet = 1;
    brk   = 1'b1;
    @(posedge clk); #1;
    check("brk_tx_low", 32'(tx), 0);
    check("brk_txrdy_low", 32'(TXRDY), 0);
    out_port = 8'h11;
    load     = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("brk_load_ignored", 32'(TXRDY), 0);
    check("brk_tx_held", 32'(tx), 0);
    brk = 1'b0;
    @(posedge clk); #1;
    check("brk_release_tx", 32'(tx), 1);
    check("brk_release_txrdy", 32'(TXRDY), 1);
    repeat (3) @(posedge clk);
    #1;
    quiet = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
